// File: rtl/lfsr_encrypt_pad_if.sv
// Handshake/config bundle for lfsr_encrypt_pad: frame launch, plaintext
// input stream, ciphertext output stream and frame-complete acknowledge.
interface lfsr_encrypt_pad_if;
    logic       Start;
    logic [4:0] PreLen;
    logic [6:0] TapPtrn;
    logic [6:0] LfsrInit;
    logic [5:0] MsgLen;
    logic [7:0] InData;
    logic       InValid;
    logic       InReady;
    logic [7:0] OutData;
    logic       OutValid;
    logic       OutReady;
    logic [5:0] OutIdx;
    logic       Ack;

    modport slave (
        input  Start, PreLen, TapPtrn, LfsrInit, MsgLen, InData, InValid, OutReady,
        output InReady, OutData, OutValid, OutIdx, Ack
    );

    modport master (
        output Start, PreLen, TapPtrn, LfsrInit, MsgLen, InData, InValid, OutReady,
        input  InReady, OutData, OutValid, OutIdx, Ack
    );
endinterface

// File: rtl/lfsr_encrypt_pad.sv
// Builds a fixed-length frame of space padding, plaintext and space tail,
// XORs each 7-bit character with a Fibonacci LFSR and appends even parity.
module lfsr_encrypt_pad #(
    parameter int FRAME_LEN = 64,
    parameter int MSG_MAX   = 54
) (
    input  logic                Clk,
    input  logic                Reset,
    lfsr_encrypt_pad_if.slave   bus
);

    typedef enum logic [2:0] {S_IDLE, S_PAD, S_MSG, S_TAIL, S_DONE} state_t;

    localparam logic [6:0] FRAME_W   = 7'(FRAME_LEN);
    localparam logic [6:0] MSG_MAX_W = 7'(MSG_MAX);
    localparam logic [5:0] LAST_IDX  = 6'(FRAME_LEN - 1);

    state_t     state_q, state_d;
    logic [6:0] pre_q, pre_d;
    logic [6:0] len_q, len_d;
    logic [6:0] taps_q, taps_d;
    logic [6:0] lfsr_q, lfsr_d;
    logic [6:0] slot_q, slot_d;
    logic [7:0] out_data_q, out_data_d;
    logic [5:0] out_idx_q, out_idx_d;
    logic       out_valid_q, out_valid_d;
    logic       ack_q, ack_d;

    // Configuration clamping applied at the moment Start is latched.
    logic [6:0] pre_in, pre_clamp, room, len_in, len_cap, len_clamp, init_fix;

    assign pre_in    = {2'b00, bus.PreLen};
    assign pre_clamp = (pre_in < 7'd10) ? 7'd10 : ((pre_in > 7'd26) ? 7'd26 : pre_in);
    assign room      = FRAME_W - pre_clamp;
    assign len_in    = {1'b0, bus.MsgLen};
    assign len_cap   = (len_in > MSG_MAX_W) ? MSG_MAX_W : len_in;
    assign len_clamp = (len_cap > room) ? room : len_cap;
    assign init_fix  = (bus.LfsrInit == 7'd0) ? 7'h01 : bus.LfsrInit;

    logic       in_frame, can_load, src_ok, load, drain;
    logic [7:0] src_char;
    logic [6:0] cipher, slot_nxt, msg_end, lfsr_adv;

    assign in_frame = (state_q == S_PAD) || (state_q == S_MSG) || (state_q == S_TAIL);
    assign can_load = !out_valid_q || bus.OutReady;
    assign drain    = out_valid_q && bus.OutReady;
    assign src_char = (state_q == S_MSG) ? bus.InData : 8'h20;
    assign src_ok   = (state_q == S_MSG) ? bus.InValid : 1'b1;
    // slot_q reaches FRAME_LEN after the final load and parks there until DONE.
    assign load     = in_frame && (slot_q < FRAME_W) && can_load && src_ok;
    assign cipher   = src_char[6:0] ^ lfsr_q;
    assign slot_nxt = slot_q + 7'd1;
    assign msg_end  = pre_q + len_q;
    assign lfsr_adv = {lfsr_q[5:0], ^(lfsr_q & taps_q)};

    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        len_d       = len_q;
        taps_d      = taps_q;
        lfsr_d      = lfsr_q;
        slot_d      = slot_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    pre_d   = pre_clamp;
                    len_d   = len_clamp;
                    taps_d  = bus.TapPtrn;
                    lfsr_d  = init_fix;
                    slot_d  = 7'd0;
                    state_d = S_PAD;
                end
            end
            S_PAD, S_MSG, S_TAIL: begin
                if (drain) begin
                    out_valid_d = 1'b0;
                end
                if (load) begin
                    out_data_d  = {^cipher, cipher};
                    out_idx_d   = slot_q[5:0];
                    out_valid_d = 1'b1;
                    lfsr_d      = lfsr_adv;
                    slot_d      = slot_nxt;
                    // Region of the next slot decides the state; an empty
                    // message or tail region is skipped naturally.
                    if (slot_nxt < pre_q) begin
                        state_d = S_PAD;
                    end else if (slot_nxt < msg_end) begin
                        state_d = S_MSG;
                    end else begin
                        state_d = S_TAIL;
                    end
                end
                if (drain && (out_idx_q == LAST_IDX)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.Start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ack_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            pre_q       <= 7'd0;
            len_q       <= 7'd0;
            taps_q      <= 7'd0;
            lfsr_q      <= 7'd0;
            slot_q      <= 7'd0;
            out_data_q  <= 8'd0;
            out_idx_q   <= 6'd0;
            out_valid_q <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            len_q       <= len_d;
            taps_q      <= taps_d;
            lfsr_q      <= lfsr_d;
            slot_q      <= slot_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            ack_q       <= ack_d;
        end
    end

    assign bus.InReady  = (state_q == S_MSG) && can_load;
    assign bus.OutData  = out_data_q;
    assign bus.OutIdx   = out_idx_q;
    assign bus.OutValid = out_valid_q;
    assign bus.Ack      = ack_q;

endmodule

// File: tb/tb_lfsr_encrypt_pad.sv
// Randomized frame-level bench for lfsr_encrypt_pad, scored against a
// slot-by-slot reference built from the padding/cipher rules.
module tb_lfsr_encrypt_pad;
    localparam int FRAME_LEN = 64;
    localparam int MSG_MAX   = 54;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lfsr_encrypt_pad_if bus();

    lfsr_encrypt_pad #(.FRAME_LEN(FRAME_LEN), .MSG_MAX(MSG_MAX)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         frame_no = 0;
    int         last_pads;
    logic [7:0] msg   [64];
    logic [7:0] exp_b [FRAME_LEN];
    logic [7:0] got_b [FRAME_LEN];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic randomize_cfg();
        bus.PreLen   = 5'($urandom);
        bus.TapPtrn  = 7'($urandom);
        bus.LfsrInit = 7'($urandom);
        bus.MsgLen   = 6'($urandom);
    endtask

    task automatic run_frame(input logic [4:0] pl, input logic [6:0] tp, input logic [6:0] li,
                             input logic [5:0] ml, input int in_pct, input int out_pct,
                             input int stall_slot, input int abort_slot,
                             input bit alpha, input bit in_hold);
        int pre, len, n_out, n_in, stall_cnt, hold_cnt;
        bit stalled, hold_done, last_acc, finished, aborted;
        logic [7:0] c, held_data;
        logic [6:0] b, s;
        logic [5:0] held_idx;

        for (int i = 0; i < 64; i++) msg[i] = alpha ? 8'(8'h41 + i) : 8'($urandom);

        // Reference: clamp, then walk the frame one slot at a time.
        pre = (pl < 10) ? 10 : ((pl > 26) ? 26 : int'(pl));
        len = int'(ml);
        if (len > MSG_MAX) len = MSG_MAX;
        if (len > FRAME_LEN - pre) len = FRAME_LEN - pre;
        s = (li == 7'd0) ? 7'h01 : li;
        for (int i = 0; i < FRAME_LEN; i++) begin
            c = (i >= pre && i < pre + len) ? msg[i - pre] : 8'h20;
            b = c[6:0] ^ s;
            exp_b[i] = {^b, b};
            s = {s[5:0], ^(s & tp)};
        end

        @(negedge clk);
        if (bus.Ack) begin
            bus.Start = 1'b1;
            @(negedge clk);
        end
        bus.Start = 1'b1;
        bus.PreLen = pl; bus.TapPtrn = tp; bus.LfsrInit = li; bus.MsgLen = ml;
        @(negedge clk);
        bus.Start = 1'b0;
        randomize_cfg();

        n_out = 0; n_in = 0; stall_cnt = 0; hold_cnt = 0; last_pads = -1;
        stalled = 0; hold_done = 0; last_acc = 0; finished = 0; aborted = 0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            bus.Start = (abort_slot < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (last_acc) begin
                bus.Start = 1'b0;
                #1;
                check_eq("ack_after_last", bus.Ack, 1);
                check_eq("valid_in_done", bus.OutValid, 0);
                finished = 1;
            end else begin
                bus.OutReady = (stall_cnt > 0) ? 1'b0 : 1'($urandom_range(1, 100) <= out_pct);
                bus.InValid  = (hold_cnt > 0) ? 1'b0 : 1'($urandom_range(1, 100) <= in_pct);
                bus.InData   = msg[n_in & 63];
                #1;
                if (stall_cnt > 0) begin
                    check_eq("stall_data", bus.OutData, held_data);
                    check_eq("stall_idx", bus.OutIdx, held_idx);
                    check_eq("stall_valid", bus.OutValid, 1);
                    check_eq("stall_inready", bus.InReady, 0);
                    stall_cnt--;
                end else if (!stalled && stall_slot >= 0 && bus.OutValid && int'(bus.OutIdx) == stall_slot) begin
                    stalled = 1;
                    stall_cnt = 4;
                    held_data = bus.OutData;
                    held_idx = bus.OutIdx;
                    bus.OutReady = 1'b0;
                    #1;
                    check_eq("stall_inready", bus.InReady, 0);
                end
                if (hold_cnt > 0) begin
                    if (hold_cnt < 4) check_eq("hold_empty", bus.OutValid, 0);
                    hold_cnt--;
                end
                if (abort_slot >= 0 && bus.OutValid && int'(bus.OutIdx) == abort_slot) begin
                    rst = 1'b1;
                    #1;
                    check_eq("rst_valid", bus.OutValid, 0);
                    check_eq("rst_data", bus.OutData, 0);
                    check_eq("rst_idx", bus.OutIdx, 0);
                    check_eq("rst_ack", bus.Ack, 0);
                    check_eq("rst_inready", bus.InReady, 0);
                    aborted = 1;
                    finished = 1;
                end else begin
                    if (bus.OutValid && bus.OutReady) begin
                        check_eq("out_idx", bus.OutIdx, n_out);
                        check_eq("out_data", bus.OutData, exp_b[n_out]);
                        got_b[n_out] = bus.OutData;
                        if (n_out == FRAME_LEN - 1) begin
                            check_eq("ack_before_done", bus.Ack, 0);
                            last_acc = 1;
                        end
                        n_out++;
                    end
                    if (bus.InReady && bus.InValid) begin
                        if (n_in == 0) last_pads = n_out;
                        n_in++;
                    end
                    if (in_hold && !hold_done && n_in == 5) begin
                        hold_done = 1;
                        hold_cnt = 4;
                    end
                end
            end
        end

        if (!finished) begin
            check_eq("frame_timeout", 0, 1);
        end else if (!aborted) begin
            check_eq("slot_count", n_out, FRAME_LEN);
            check_eq("chars_consumed", n_in, len);
        end
        frame_no++;
        $display("frame %0d: pre=%0d len=%0d outputs=%0d consumed=%0d aborted=%0d",
                 frame_no, pre, len, n_out, n_in, aborted);
    endtask

    logic [7:0] first_slot;

    initial begin
        bus.Start = 1'b0; bus.InData = 8'h00; bus.InValid = 1'b0; bus.OutReady = 1'b0;
        bus.PreLen = 5'd0; bus.TapPtrn = 7'd0; bus.LfsrInit = 7'd0; bus.MsgLen = 6'd0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_valid", bus.OutValid, 0);
        check_eq("reset_data", bus.OutData, 0);
        check_eq("reset_idx", bus.OutIdx, 0);
        check_eq("reset_ack", bus.Ack, 0);
        check_eq("reset_inready", bus.InReady, 0);
        rst = 1'b0;

        run_frame(5'd12, 7'h60, 7'h47, 6'd0, 100, 100, -1, -1, 1'b0, 1'b0);
        check_eq("nominal_slot0", got_b[0], 8'hE7);
        check_eq("nominal_slot1", got_b[1], 8'hAF);

        run_frame(5'd12, 7'h60, 7'h00, 6'd0, 100, 100, -1, -1, 1'b0, 1'b0);
        check_eq("zero_init_slot0", got_b[0], 8'h21);

        run_frame(5'd5, 7'h60, 7'h47, 6'd54, 100, 100, -1, -1, 1'b1, 1'b0);
        check_eq("clamp_pad_slots", last_pads, 10);

        run_frame(5'd12, 7'h60, 7'h47, 6'd20, 100, 100, 3, -1, 1'b0, 1'b0);

        for (int k = 0; k < 10; k++) begin
            run_frame(5'($urandom), 7'($urandom), 7'($urandom), 6'($urandom),
                      $urandom_range(40, 100), $urandom_range(40, 100),
                      (k % 3 == 0) ? int'($urandom_range(0, 63)) : -1, -1, 1'b0, 1'b0);
        end

        run_frame(5'd10, 7'h60, 7'h47, 6'd40, 100, 100, -1, 30, 1'b0, 1'b1);
        first_slot = exp_b[0];
        @(negedge clk);
        rst = 1'b0;
        run_frame(5'd10, 7'h60, 7'h47, 6'd40, 100, 100, -1, -1, 1'b0, 1'b0);
        check_eq("restart_slot0", got_b[0], first_slot);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
